// File: rtl/lpc_ring_scheduler_if.sv
// Bundle of all non-clock signals around the capture-ring scheduler: the record
// input from the LPC decoder, the external 1R1W ring RAM port, the UART byte
// stream and the ring status flags.
interface lpc_ring_scheduler_if #(
    parameter int BITS  = 5,
    parameter int WIDTH = 48
);
    // Record input from the LPC decoder
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             ovf_clear;

    // External ring RAM (write port combinational, read port registered)
    logic             ram_we;
    logic [BITS-1:0]  ram_waddr;
    logic [WIDTH-1:0] ram_wdata;
    logic [BITS-1:0]  ram_raddr;
    logic [WIDTH-1:0] ram_rdata;

    // Byte stream to the UART
    logic [7:0]       tx_byte;
    logic             tx_valid;
    logic             tx_ready;

    // Ring status
    logic             empty;
    logic             full;
    logic             overflow;
    logic [15:0]      drop_count;

    // Scheduler side: drives the RAM port, byte stream and status.
    modport master (
        input  in_valid, in_data, ovf_clear, ram_rdata, tx_ready,
        output ram_we, ram_waddr, ram_wdata, ram_raddr,
               tx_byte, tx_valid, empty, full, overflow, drop_count
    );

    // Environment side: decoder, RAM and UART.
    modport slave (
        output in_valid, in_data, ovf_clear, ram_rdata, tx_ready,
        input  ram_we, ram_waddr, ram_wdata, ram_raddr,
               tx_byte, tx_valid, empty, full, overflow, drop_count
    );
endinterface

// File: rtl/lpc_ring_scheduler.sv
// Capture-ring scheduler: writes decoded LPC records into an external ring RAM
// and drains them, oldest first, as an MSB-first byte stream to the UART.
// Records arriving while the ring is full are dropped and counted.
module lpc_ring_scheduler #(
    parameter int BITS  = 5,
    parameter int WIDTH = 48
) (
    input  logic                  clk,
    input  logic                  reset,
    lpc_ring_scheduler_if.master  bus
);

    localparam int BYTES = WIDTH / 8;
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

    // Occupancy value meaning "every slot holds a record".
    localparam logic [BITS:0] FULL_COUNT = {1'b1, {BITS{1'b0}}};

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        LOAD,
        SEND
    } state_e;

    // Pointers carry one extra MSB so that full and empty are distinguishable.
    logic [BITS:0]      wr_ptr_q;
    logic [BITS:0]      rd_ptr_q,     rd_ptr_d;
    logic [BITS:0]      count;

    state_e             state_q,      state_d;
    logic [BITS-1:0]    raddr_q,      raddr_d;
    logic [WIDTH-1:0]   shreg_q,      shreg_d;
    logic [CNT_W-1:0]   byte_cnt_q,   byte_cnt_d;
    logic               tx_valid_q,   tx_valid_d;
    logic [7:0]         tx_byte_q,    tx_byte_d;

    logic               overflow_q,   overflow_d;
    logic [15:0]        drop_count_q, drop_count_d;

    logic               empty_w;
    logic               full_w;
    logic               wr_en;
    logic               drop;
    logic [WIDTH-1:0]   shifted;

    // Ring occupancy and write/drop decisions (current count only).
    assign count   = wr_ptr_q - rd_ptr_q;
    assign empty_w = (count == '0);
    assign full_w  = (count == FULL_COUNT);
    assign wr_en   = bus.in_valid & ~full_w & ~reset;
    assign drop    = bus.in_valid & full_w;
    assign shifted = shreg_q << 8;

    assign bus.ram_we     = wr_en;
    assign bus.ram_waddr  = wr_ptr_q[BITS-1:0];
    assign bus.ram_wdata  = bus.in_data;
    assign bus.ram_raddr  = raddr_q;
    assign bus.tx_byte    = tx_byte_q;
    assign bus.tx_valid   = tx_valid_q;
    assign bus.empty      = empty_w;
    assign bus.full       = full_w;
    assign bus.overflow   = overflow_q;
    assign bus.drop_count = drop_count_q;

    // Advance the write pointer for every record accepted into the ring.
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking (=) here would create order-dependent races.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
        end else if (wr_en) begin
            wr_ptr_q <= wr_ptr_q + (BITS+1)'(1);
        end
    end

    // Next value of the sticky overflow flag and saturating drop counter.
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        overflow_d   = overflow_q;
        drop_count_d = drop_count_q;
        if (drop) begin
            // A drop wins over a simultaneous clear: it is the first new drop.
            overflow_d = 1'b1;
            if (bus.ovf_clear) begin
                drop_count_d = 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end else if (bus.ovf_clear) begin
            overflow_d   = 1'b0;
            drop_count_d = '0;
        end
    end

    // Overflow flag and drop counter registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            overflow_q   <= overflow_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Read FSM next state: fetch the oldest record, then serialise it MSB first.
    always_comb begin
        state_d    = state_q;
        raddr_d    = raddr_q;
        shreg_d    = shreg_q;
        byte_cnt_d = byte_cnt_q;
        tx_valid_d = tx_valid_q;
        tx_byte_d  = tx_byte_q;
        rd_ptr_d   = rd_ptr_q;
        unique case (state_q)
            IDLE: begin
                if (!empty_w) begin
                    raddr_d = rd_ptr_q[BITS-1:0];
                    state_d = FETCH;
                end
            end
            FETCH: begin
                // RAM read in flight; data is on ram_rdata in LOAD.
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d    = bus.ram_rdata;
                byte_cnt_d = CNT_W'(BYTES - 1);
                tx_valid_d = 1'b1;
                tx_byte_d  = bus.ram_rdata[WIDTH-1 -: 8];
                state_d    = SEND;
            end
            SEND: begin
                if (bus.tx_ready) begin
                    if (byte_cnt_q == '0) begin
                        // Slot is released only once its last byte is taken.
                        rd_ptr_d   = rd_ptr_q + (BITS+1)'(1);
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        shreg_d    = shifted;
                        tx_byte_d  = shifted[WIDTH-1 -: 8];
                        byte_cnt_d = byte_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Read FSM state and datapath registers; reset abandons any record in flight.
    // NOTE: the record shift register is reset along with the control state so
    // tx_byte and every internal register come out of reset at a known value.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            raddr_q    <= '0;
            shreg_q    <= '0;
            byte_cnt_q <= '0;
            tx_valid_q <= 1'b0;
            tx_byte_q  <= '0;
            rd_ptr_q   <= '0;
        end else begin
            state_q    <= state_d;
            raddr_q    <= raddr_d;
            shreg_q    <= shreg_d;
            byte_cnt_q <= byte_cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_byte_q  <= tx_byte_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

endmodule
